// File: rtl/regfile_port_arbiter_pkg.sv
// Shared constants, port identifiers and helpers for the register-file port arbiter.
package regfile_port_arbiter_pkg;

  localparam int unsigned NumRegs  = 32;
  localparam int unsigned RegAddrW = $clog2(NumRegs);
  localparam int unsigned Xlen     = 64;

  localparam logic [RegAddrW-1:0] ZeroRegIdx = '0;

  typedef enum logic {
    PortCore  = 1'b0,
    PortDebug = 1'b1
  } port_id_e;

  // Counter width able to hold 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

  function automatic logic is_zero_reg(logic en, logic [RegAddrW-1:0] addr);
    return en && (addr == ZeroRegIdx);
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_starve_counter.sv
// Saturating count of cycles the debug port has been denied; at_max_o lets it win.
module regfile_port_arbiter_starve_counter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int unsigned MaxWait = 4,
  localparam int unsigned CntW   = cnt_width(MaxWait)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  assign at_max_o = (cnt_q == CntW'(MaxWait));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Two-port arbiter in front of the register file: core has priority, debug is
// guaranteed progress after MaxWait denied cycles. Read data returns one cycle later.
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int unsigned MaxWait = 4,
  parameter bit          ZeroReg = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                p0_req_i,
  input  logic                p0_we_i,
  input  logic [RegAddrW-1:0] p0_ra_i,
  input  logic [RegAddrW-1:0] p0_rb_i,
  input  logic [RegAddrW-1:0] p0_wa_i,
  input  logic [Xlen-1:0]     p0_wd_i,
  input  logic                p1_req_i,
  input  logic                p1_we_i,
  input  logic [RegAddrW-1:0] p1_ra_i,
  input  logic [RegAddrW-1:0] p1_rb_i,
  input  logic [RegAddrW-1:0] p1_wa_i,
  input  logic [Xlen-1:0]     p1_wd_i,
  output logic                p0_gnt_o,
  output logic                p1_gnt_o,
  output logic                rsp_valid_o,
  output logic                rsp_id_o,
  output logic [Xlen-1:0]     rsp_a_o,
  output logic [Xlen-1:0]     rsp_b_o,
  output logic [RegAddrW-1:0] rf_RN1_o,
  output logic [RegAddrW-1:0] rf_RN2_o,
  output logic [RegAddrW-1:0] rf_WN_o,
  output logic [Xlen-1:0]     rf_WD_o,
  output logic                rf_RegWrite_o,
  input  logic [Xlen-1:0]     rf_RD1_i,
  input  logic [Xlen-1:0]     rf_RD2_i
);

  logic                p0_gnt, p1_gnt, p1_win, any_gnt, sel_we, wait_at_max;
  logic [RegAddrW-1:0] rn1, rn2, wn;

  logic     rsp_valid_d, rsp_valid_q;
  port_id_e rsp_id_d, rsp_id_q;
  logic     zero_a_d, zero_a_q;
  logic     zero_b_d, zero_b_q;

  // Grants are forced low while reset is asserted.
  always_comb begin
    p1_win  = p1_req_i & (wait_at_max | ~p0_req_i);
    p1_gnt  = rst_ni & p1_win;
    p0_gnt  = rst_ni & p0_req_i & ~p1_win;
    any_gnt = p0_gnt | p1_gnt;
  end

  // With no grant the port-0 fields pass through; RegWrite stays low.
  always_comb begin
    rn1    = p1_gnt ? p1_ra_i : p0_ra_i;
    rn2    = p1_gnt ? p1_rb_i : p0_rb_i;
    wn     = p1_gnt ? p1_wa_i : p0_wa_i;
    sel_we = p1_gnt ? p1_we_i : p0_we_i;
  end

  assign p0_gnt_o      = p0_gnt;
  assign p1_gnt_o      = p1_gnt;
  assign rf_RN1_o      = rn1;
  assign rf_RN2_o      = rn2;
  assign rf_WN_o       = wn;
  assign rf_WD_o       = p1_gnt ? p1_wd_i : p0_wd_i;
  assign rf_RegWrite_o = any_gnt & sel_we & ~is_zero_reg(ZeroReg, wn);

  regfile_port_arbiter_starve_counter #(
    .MaxWait (MaxWait)
  ) u_starve_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (p1_gnt | ~p1_req_i),
    .inc_i    (p1_req_i & p0_gnt),
    .at_max_o (wait_at_max)
  );

  always_comb begin
    rsp_valid_d = any_gnt;
    rsp_id_d    = p1_gnt ? PortDebug : PortCore;
    zero_a_d    = is_zero_reg(ZeroReg, rn1);
    zero_b_d    = is_zero_reg(ZeroReg, rn2);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= PortCore;
      zero_a_q    <= 1'b0;
      zero_b_q    <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      zero_a_q    <= zero_a_d;
      zero_b_q    <= zero_b_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_a_o     = zero_a_q ? '0 : rf_RD1_i;
  assign rsp_b_o     = zero_b_q ? '0 : rf_RD2_i;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural register file
// (reads registered on posedge, writes on negedge).
module tb_regfile_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [4:0]  p0_ra, p0_rb, p0_wa, p1_ra, p1_rb, p1_wa;
  logic [63:0] p0_wd, p1_wd;
  logic        p0_gnt, p1_gnt, rsp_valid, rsp_id;
  logic [63:0] rsp_a, rsp_b;
  logic [4:0]  rn1, rn2, wn;
  logic [63:0] wd, rd1, rd2;
  logic        rf_we;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] mem [32];
  logic        mem_ready = 1'b0;

  localparam logic [63:0] ValX5 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] ValX0 = 64'h0000_0000_0000_0BAD;

  always #5 clk = ~clk;

  regfile_port_arbiter dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .p0_req_i      (p0_req),
    .p0_we_i       (p0_we),
    .p0_ra_i       (p0_ra),
    .p0_rb_i       (p0_rb),
    .p0_wa_i       (p0_wa),
    .p0_wd_i       (p0_wd),
    .p1_req_i      (p1_req),
    .p1_we_i       (p1_we),
    .p1_ra_i       (p1_ra),
    .p1_rb_i       (p1_rb),
    .p1_wa_i       (p1_wa),
    .p1_wd_i       (p1_wd),
    .p0_gnt_o      (p0_gnt),
    .p1_gnt_o      (p1_gnt),
    .rsp_valid_o   (rsp_valid),
    .rsp_id_o      (rsp_id),
    .rsp_a_o       (rsp_a),
    .rsp_b_o       (rsp_b),
    .rf_RN1_o      (rn1),
    .rf_RN2_o      (rn2),
    .rf_WN_o       (wn),
    .rf_WD_o       (wd),
    .rf_RegWrite_o (rf_we),
    .rf_RD1_i      (rd1),
    .rf_RD2_i      (rd2)
  );

  // Register file: x0 holds a non-zero value so zero-forcing is observable.
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 32; i++) mem[i] <= {32'hA5A5_0000, 32'(i)};
      mem[0]    <= ValX0;
      mem_ready <= 1'b1;
    end else if (rf_we) begin
      mem[wn] <= wd;
    end
  end

  always @(posedge clk) begin
    rd1 <= mem[rn1];
    rd2 <= mem[rn2];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_p0(input logic req, input logic we, input logic [4:0] ra,
                          input logic [4:0] rb, input logic [4:0] wa, input logic [63:0] d);
    p0_req = req; p0_we = we; p0_ra = ra; p0_rb = rb; p0_wa = wa; p0_wd = d;
  endtask

  task automatic drive_p1(input logic req, input logic we, input logic [4:0] ra,
                          input logic [4:0] rb, input logic [4:0] wa, input logic [63:0] d);
    p1_req = req; p1_we = we; p1_ra = ra; p1_rb = rb; p1_wa = wa; p1_wd = d;
  endtask

  task automatic test_reset();
    drive_p0(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 64'h1);
    drive_p1(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 64'h2);
    #1;
    n_cmp++; if (p0_gnt !== 1'b0) begin n_err++; $display("FAIL reset_p0_gnt: got %b want 0", p0_gnt); end
    n_cmp++; if (p1_gnt !== 1'b0) begin n_err++; $display("FAIL reset_p1_gnt: got %b want 0", p1_gnt); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL reset_rsp_id: got %b want 0", rsp_id); end
    n_cmp++; if (dut.u_starve_cnt.cnt_q !== 3'd0) begin n_err++; $display("FAIL reset_wait_cnt: got %0d want 0", dut.u_starve_cnt.cnt_q); end
    drive_p0(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
    drive_p1(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_core();
    drive_p0(1'b1, 1'b1, 5'd0, 5'd0, 5'd5, ValX5);
    #1;
    n_cmp++; if (p0_gnt !== 1'b1) begin n_err++; $display("FAIL single_gnt: got %b want 1", p0_gnt); end
    n_cmp++; if (rf_we !== 1'b1 || wn !== 5'd5) begin n_err++; $display("FAIL single_wr: got we=%b wn=%0d want we=1 wn=5", rf_we, wn); end
    tick();
    drive_p0(1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 64'h0);
    tick();
    drive_p0(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin n_err++; $display("FAIL single_rsp: got v=%b id=%b want v=1 id=0", rsp_valid, rsp_id); end
    n_cmp++; if (rsp_a !== ValX5) begin n_err++; $display("FAIL single_rsp_a: got %h want %h", rsp_a, ValX5); end
    n_cmp++; if (rsp_b !== 64'h0) begin n_err++; $display("FAIL single_rsp_b: got %h want 0", rsp_b); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0", rsp_valid); end
  endtask

  task automatic test_read_own_write();
    drive_p0(1'b1, 1'b1, 5'd7, 5'd5, 5'd7, 64'h1234);
    tick();
    drive_p0(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
    n_cmp++; if (rsp_a !== 64'h1234) begin n_err++; $display("FAIL own_write_a: got %h want 1234", rsp_a); end
    n_cmp++; if (rsp_b !== ValX5) begin n_err++; $display("FAIL own_write_b: got %h want %h", rsp_b, ValX5); end
    tick();
  endtask

  task automatic test_zero_reg();
    drive_p1(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 64'hFFFF);
    #1;
    n_cmp++; if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin n_err++; $display("FAIL zero_gnt: got p0=%b p1=%b want p0=0 p1=1", p0_gnt, p1_gnt); end
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL zero_regwrite: got %b want 0", rf_we); end
    tick();
    drive_p1(1'b1, 1'b0, 5'd0, 5'd7, 5'd0, 64'h0);
    n_cmp++; if (rsp_id !== 1'b1 || rsp_a !== 64'h0) begin n_err++; $display("FAIL zero_rsp1: got id=%b a=%h want id=1 a=0", rsp_id, rsp_a); end
    tick();
    drive_p1(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
    n_cmp++; if (rsp_a !== 64'h0 || rsp_b !== 64'h1234) begin n_err++; $display("FAIL zero_read: got a=%h b=%h want a=0 b=1234", rsp_a, rsp_b); end
    n_cmp++; if (mem[0] !== ValX0) begin n_err++; $display("FAIL zero_mem: got %h want %h", mem[0], ValX0); end
    tick();
  endtask

  task automatic test_starvation();
    logic exp_p1, prev_p1;
    prev_p1 = 1'b0;
    drive_p0(1'b1, 1'b0, 5'd5, 5'd7, 5'd0, 64'h0);
    drive_p1(1'b1, 1'b0, 5'd7, 5'd5, 5'd0, 64'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_p1 = ((i % 5) == 4);
      n_cmp++; if (p1_gnt !== exp_p1 || p0_gnt !== !exp_p1) begin n_err++; $display("FAIL starve_gnt[%0d]: got p0=%b p1=%b want p1=%b", i, p0_gnt, p1_gnt, exp_p1); end
      n_cmp++; if (dut.u_starve_cnt.cnt_q !== 3'(i % 5)) begin n_err++; $display("FAIL starve_cnt[%0d]: got %0d want %0d", i, dut.u_starve_cnt.cnt_q, i % 5); end
      if (i > 0) begin
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== prev_p1) begin n_err++; $display("FAIL starve_rsp[%0d]: got v=%b id=%b want v=1 id=%b", i, rsp_valid, rsp_id, prev_p1); end
        n_cmp++; if (rsp_a !== (prev_p1 ? 64'h1234 : ValX5)) begin n_err++; $display("FAIL starve_data[%0d]: got %h", i, rsp_a); end
      end
      prev_p1 = exp_p1;
      tick();
    end
    drive_p0(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
    drive_p1(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [63:0] v;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        v = {32'hB2B0_0000, 32'(k - 1)};
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'((k - 1) % 2)) begin n_err++; $display("FAIL b2b_rsp[%0d]: got v=%b id=%b want v=1 id=%0d", k - 1, rsp_valid, rsp_id, (k - 1) % 2); end
        n_cmp++; if (rsp_a !== v) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", k - 1, rsp_a, v); end
      end
      if (k < 8) begin
        v = {32'hB2B0_0000, 32'(k)};
        drive_p0((k % 2) == 0, 1'b1, 5'(10 + k), 5'd0, 5'(10 + k), v);
        drive_p1((k % 2) == 1, 1'b1, 5'(10 + k), 5'd0, 5'(10 + k), v);
        #1;
        n_cmp++; if (p1_gnt !== 1'((k % 2) == 1)) begin n_err++; $display("FAIL b2b_gnt[%0d]: got p1=%b want %0d", k, p1_gnt, k % 2); end
        @(posedge clk);
        #1;
      end else begin
        drive_p0(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
        drive_p1(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
        tick();
      end
    end
    // Read back all eight registers, two per operation.
    for (int j = 0; j <= 4; j++) begin
      if (j > 0) begin
        v = {32'hB2B0_0000, 32'(2 * (j - 1))};
        n_cmp++; if (rsp_a !== v) begin n_err++; $display("FAIL b2b_rb_a[%0d]: got %h want %h", j - 1, rsp_a, v); end
        v = {32'hB2B0_0000, 32'(2 * (j - 1) + 1)};
        n_cmp++; if (rsp_b !== v) begin n_err++; $display("FAIL b2b_rb_b[%0d]: got %h want %h", j - 1, rsp_b, v); end
      end
      if (j < 4) drive_p0(1'b1, 1'b0, 5'(10 + 2 * j), 5'(11 + 2 * j), 5'd0, 64'h0);
      else       drive_p0(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
      tick();
    end
  endtask

  task automatic test_same_reg();
    drive_p0(1'b1, 1'b1, 5'd0, 5'd0, 5'd20, 64'hAAAA);
    drive_p1(1'b1, 1'b1, 5'd0, 5'd0, 5'd20, 64'hBBBB);
    #1;
    n_cmp++; if (p0_gnt !== 1'b1) begin n_err++; $display("FAIL same_first: got p0=%b want 1", p0_gnt); end
    tick();
    drive_p0(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
    #1;
    n_cmp++; if (p1_gnt !== 1'b1) begin n_err++; $display("FAIL same_second: got p1=%b want 1", p1_gnt); end
    tick();
    drive_p1(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
    drive_p0(1'b1, 1'b0, 5'd20, 5'd0, 5'd0, 64'h0);
    tick();
    drive_p0(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
    n_cmp++; if (rsp_a !== 64'hBBBB) begin n_err++; $display("FAIL same_last_writer: got %h want bbbb", rsp_a); end
    tick();
  endtask

  task automatic test_reset_midstream();
    drive_p0(1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 64'h0);
    drive_p1(1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 64'h0);
    tick();
    tick();
    n_cmp++; if (rsp_valid !== 1'b1 || dut.u_starve_cnt.cnt_q !== 3'd2) begin n_err++; $display("FAIL mid_pre: got v=%b cnt=%0d want v=1 cnt=2", rsp_valid, dut.u_starve_cnt.cnt_q); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (dut.u_starve_cnt.cnt_q !== 3'd0) begin n_err++; $display("FAIL mid_wait_cnt: got %0d want 0", dut.u_starve_cnt.cnt_q); end
    n_cmp++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin n_err++; $display("FAIL mid_gnt: got p0=%b p1=%b want 0", p0_gnt, p1_gnt); end
    drive_p0(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
    drive_p1(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive_p0(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
    drive_p1(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single_core();
    test_read_own_write();
    test_zero_reg();
    test_starvation();
    test_back_to_back();
    test_same_reg();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
